ie_arbiter: RTL and testbench
=============================

// Module: ie_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 16-bit execute-stage ALU between up to 4 requesters.
//  Issue registers drive the ALU. A tag pipeline matches each ALU result to its requester.
//  Sits between the requester ports (decode/issue lanes) and the ALU instance.
//  The ALU has an active-high reset; the top level drives it with ~rst.
// PARAMETERS
//  NUM_REQ    2   number of requesters; legal range 2..4
//  ALU_LAT    1   ALU result latency in clk cycles (execute stage registers its result once)
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous reset, active-low (asserted while 0)
//  req_valid     in   NUM_REQ      requester i has an operation pending
//  req_ready     out  NUM_REQ      one-hot grant; operation i accepted on the edge where valid&ready
//  req_data1     in   16*NUM_REQ   operand A; requester i uses bits [16i+15:16i]
//  req_data2     in   16*NUM_REQ   operand B; same packing as req_data1
//  req_opcode    in   4*NUM_REQ    opcode; requester i uses bits [4i+3:4i]
//  stall         in   1            1 = grant nothing this cycle; in-flight ops still complete
//  alu_data1     out  16           registered operand A to ALU
//  alu_data2     out  16           registered operand B to ALU
//  alu_opcode    out  4            registered opcode to ALU
//  alu_result    in   16           ALU result, valid ALU_LAT cycles after the issue registers load
//  resp_valid    out  1            1-cycle pulse: resp_* carry one completed operation
//  resp_id       out  2            requester index of the completed operation
//  resp_result   out  16           captured alu_result
//  resp_err      out  1            1 = opcode was outside 0..4 (ALU returns 0); the result is still delivered
//  issue_cnt     out  16           number of accepted operations; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all outputs = 0; the tag pipeline is cleared, so no resp_valid for in-flight ops.
//   - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
//  Grant (combinational):
//   - While stall=0, search for the first set req_valid starting at (rr_ptr+1) mod NUM_REQ, wrapping.
//   - Exactly that requester's req_ready = 1. No valid requester, or stall=1 -> req_ready = 0.
//  Accept edge (valid & ready):
//   - The granted data1/data2/opcode load into alu_*. rr_ptr <= granted index.
//   - issue_cnt increments.
//   - Tag {1, id, opcode>4} enters stage 0 of the ALU_LAT+1 deep tag pipeline.
//  No-accept edge:
//   - alu_* hold their previous value; rr_ptr holds; a tag with valid=0 enters the pipeline.
//  Pipeline timing:
//   - The tag pipeline shifts every cycle, with no backpressure.
//   - When the final tag stage is valid, resp_result <= alu_result and resp_id/resp_err come from that tag on the same edge.
//   - resp_valid is high for exactly that one cycle.
//   - Latency: accept edge E0 -> resp_valid high in the cycle after edge E0+ALU_LAT+1 (2 edges for ALU_LAT=1).
//   - Throughput: 1 op/cycle. Back-to-back responses arrive in accept order.
//  Boundary cases:
//   - req_valid drops without ready -> no effect; no request is queued.
//   - A single active requester is granted every cycle.
//   - stall asserted mid-stream -> no new tags; responses already in flight still emerge on schedule.
//   - Indices >= NUM_REQ do not exist; ID bits above the NUM_REQ range are 0.
//   - Operand arithmetic belongs entirely to the ALU; the arbiter never modifies data.
//  Reset asserted mid-operation -> everything clears immediately. After release, the first grant goes to requester 0.
// TESTING
//  1) Single op: req0 valid, 0x1234 ADD 0x0011 (op 0) -> ready0 in that cycle;
//     resp_valid 2 edges after accept with id=0, result 0x1245, err=0.
//  2) Contention: req0 and req1 held valid for 4 cycles after reset ->
//     grants alternate 0,1,0,1 and responses arrive in the same order.
//  3) Opcode 7 from req1, data 0xFFFF/0x0001 -> resp id=1, result 0x0000, resp_err=1.
//  4) Stall: ops continuously valid, stall=1 for 3 cycles ->
//     zero grants during stall, 2 already in-flight responses still arrive, round-robin resumes afterwards.
//  5) Reset mid-stream: drop rst one cycle after accept ->
//     outputs 0, no resp_valid for that op, issue_cnt=0, next grant goes to requester 0.
//  6) Wrap: preload traffic for 65536 accepts -> issue_cnt returns to 0x0000; results remain correct.

Source files
------------

// File: rtl/ie_arbiter_if.sv
// Signal bundle between ie_arbiter and its requesters, ALU and response consumer.
interface ie_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [16*NUM_REQ-1:0]   req_data1;
    logic [16*NUM_REQ-1:0]   req_data2;
    logic [4*NUM_REQ-1:0]    req_opcode;
    logic                    stall;
    logic [15:0]             alu_data1;
    logic [15:0]             alu_data2;
    logic [3:0]              alu_opcode;
    logic [15:0]             alu_result;
    logic                    resp_valid;
    logic [1:0]              resp_id;
    logic [15:0]             resp_result;
    logic                    resp_err;
    logic [15:0]             issue_cnt;

    // Arbiter side.
    modport slave (
        input  req_valid, req_data1, req_data2, req_opcode, stall, alu_result,
        output req_ready, alu_data1, alu_data2, alu_opcode,
               resp_valid, resp_id, resp_result, resp_err, issue_cnt
    );

    // Environment side: requesters, the ALU and the response consumer.
    modport master (
        output req_valid, req_data1, req_data2, req_opcode, stall, alu_result,
        input  req_ready, alu_data1, alu_data2, alu_opcode,
               resp_valid, resp_id, resp_result, resp_err, issue_cnt
    );
endinterface

// File: rtl/ie_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between NUM_REQ requesters.
// Accepted operands are registered toward the ALU; a tag pipeline running
// alongside the ALU pairs each result with the requester that issued it.
module ie_arbiter #(
    parameter int NUM_REQ = 2,   // 2..4
    parameter int ALU_LAT = 1    // ALU result latency in cycles
) (
    input  logic        clk,
    input  logic        rst,     // asynchronous, active-low
    ie_arbiter_if.slave bus
);

    typedef struct packed {
        logic       vld;
        logic [1:0] id;
        logic       err;
    } tag_t;

    logic [1:0]         rr_ptr_q;
    logic [1:0]         rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [1:0]         grant_id;
    logic [15:0]        sel_data1;
    logic [15:0]        sel_data2;
    logic [3:0]         sel_opcode;
    logic [15:0]        alu_data1_q;
    logic [15:0]        alu_data2_q;
    logic [3:0]         alu_opcode_q;
    logic [15:0]        issue_cnt_q;
    logic [15:0]        issue_cnt_d;
    tag_t               tag_d;
    tag_t               tag_q [ALU_LAT+1];
    logic               resp_valid_q;
    logic [1:0]         resp_id_q;
    logic [15:0]        resp_result_q;
    logic               resp_err_q;

    // Rotating-priority search: first valid requester after the last one granted.
    // NOTE: every variable written here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        if (!bus.stall) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                idx = (int'(rr_ptr_q) + off) % NUM_REQ;
                if (!grant_vld && bus.req_valid[idx]) begin
                    grant_vld  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = 2'(idx);
                end
            end
        end
    end

    // Operand mux for the granted lane plus next-state values.
    always_comb begin
        sel_data1  = '0;
        sel_data2  = '0;
        sel_opcode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data1  = bus.req_data1[16*i +: 16];
                sel_data2  = bus.req_data2[16*i +: 16];
                sel_opcode = bus.req_opcode[4*i +: 4];
            end
        end
        rr_ptr_d    = grant_vld ? grant_id : rr_ptr_q;
        issue_cnt_d = grant_vld ? issue_cnt_q + 16'd1 : issue_cnt_q;
        tag_d.vld   = grant_vld;
        tag_d.id    = grant_id;
        tag_d.err   = grant_vld && (sel_opcode > 4'd4);
    end

    // Issue registers, round-robin pointer and accept counter.
    // NOTE: non-blocking assignments make every register sample pre-edge values, so rr_ptr_q never feeds the grant search mid-update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_opcode_q <= '0;
            rr_ptr_q     <= 2'(NUM_REQ - 1);
            issue_cnt_q  <= '0;
        end else begin
            if (grant_vld) begin
                alu_data1_q  <= sel_data1;
                alu_data2_q  <= sel_data2;
                alu_opcode_q <= sel_opcode;
            end
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Tag pipeline: shifts every cycle, one stage per ALU cycle plus the issue stage.
    // NOTE: this storage array is reset on purpose; its valid bits alone decide whether a response is emitted, so stale tags must not survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s <= ALU_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s <= ALU_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Response capture: pair the ALU result with the tag leaving the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            resp_valid_q <= tag_q[ALU_LAT].vld;
            if (tag_q[ALU_LAT].vld) begin
                resp_id_q     <= tag_q[ALU_LAT].id;
                resp_err_q    <= tag_q[ALU_LAT].err;
                resp_result_q <= bus.alu_result;
            end
        end
    end

    // Grants are suppressed while reset is held so every output reads zero.
    assign bus.req_ready   = grant & {NUM_REQ{rst}};
    assign bus.alu_data1   = alu_data1_q;
    assign bus.alu_data2   = alu_data2_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_ie_arbiter.sv
// Self-checking bench for ie_arbiter with three requesters and a one-cycle ALU.
module tb_ie_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ie_arbiter_if #(.NUM_REQ(N)) bus ();

    ie_arbiter #(.NUM_REQ(N), .ALU_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU opcode set: ADD, SUB, AND, OR, XOR; anything else returns 0.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    // Environment ALU: registers its result once, held in reset by ~rst.
    logic alu_rst;
    assign alu_rst = ~rst;
    always @(posedge clk or posedge alu_rst) begin
        if (alu_rst) bus.alu_result <= '0;
        else         bus.alu_result <= alu_f(bus.alu_data1, bus.alu_data2, bus.alu_opcode);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: last granted index, accept count, issued operands and
    // a queue of expected responses stamped with the cycle they must appear in.
    typedef struct {
        int          due;
        int          id;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          resp_log[$];
    int          ncyc = 0;
    int          m_last = N - 1;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_d1 = '0;
    logic [15:0] m_d2 = '0;
    logic [3:0]  m_op = '0;

    // Compare process: runs on every falling edge, then advances the model.
    always @(negedge clk) begin : monitor
        int           want;
        int           idx;
        logic [N-1:0] want_ready;
        ncyc       = ncyc + 1;
        want       = -1;
        idx        = 0;
        want_ready = '0;
        if (!rst) begin
            exp_q.delete();
            m_last = N - 1;
            m_cnt  = '0;
            m_d1   = '0;
            m_d2   = '0;
            m_op   = '0;
            check("rst_ready", 32'(bus.req_ready), 0);
            check("rst_resp_valid", 32'(bus.resp_valid), 0);
            check("rst_resp_result", 32'(bus.resp_result), 0);
            check("rst_issue_cnt", 32'(bus.issue_cnt), 0);
            check("rst_alu_data1", 32'(bus.alu_data1), 0);
            check("rst_alu_opcode", 32'(bus.alu_opcode), 0);
        end else begin
            if (!bus.stall) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (want < 0 && bus.req_valid[idx]) want = idx;
                end
            end
            if (want >= 0) want_ready[want] = 1'b1;
            check("ready", 32'(bus.req_ready), 32'(want_ready));
            check("issue_cnt", 32'(bus.issue_cnt), 32'(m_cnt));
            check("alu_data1", 32'(bus.alu_data1), 32'(m_d1));
            check("alu_data2", 32'(bus.alu_data2), 32'(m_d2));
            check("alu_opcode", 32'(bus.alu_opcode), 32'(m_op));
            if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
                check("resp_valid", 32'(bus.resp_valid), 1);
                check("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
                check("resp_result", 32'(bus.resp_result), 32'(exp_q[0].res));
                check("resp_err", 32'(bus.resp_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end else begin
                check("resp_idle", 32'(bus.resp_valid), 0);
            end
            if (want >= 0) begin
                m_last = want;
                m_cnt  = m_cnt + 16'd1;
                m_d1   = bus.req_data1[16*want +: 16];
                m_d2   = bus.req_data2[16*want +: 16];
                m_op   = bus.req_opcode[4*want +: 4];
                exp_q.push_back('{ncyc + 3, want, alu_f(m_d1, m_d2, m_op), (m_op > 4'd4)});
            end
        end
    end

    // Response recorder used to pin ordering in the directed scenarios.
    always @(negedge clk) begin
        if (bus.resp_valid) resp_log.push_back(int'(bus.resp_id));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] op);
        bus.req_valid[i]          = v;
        bus.req_data1[16*i +: 16] = a;
        bus.req_data2[16*i +: 16] = b;
        bus.req_opcode[4*i +: 4]  = op;
    endtask

    task automatic drive_rand(input int i);
        drive(i, 1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.stall     = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_data1  = '0;
        bus.req_data2  = '0;
        bus.req_opcode = '0;
        bus.stall      = 1'b0;
        rst            = 1'b0;

        // Reset holds every output at zero even with a request pending.
        drive(0, 1'b1, 16'h1234, 16'h0011, 4'd0);
        step();
        step();
        check("reset_ready", 32'(bus.req_ready), 0);
        check("reset_cnt", 32'(bus.issue_cnt), 0);

        // Single ADD from requester 0.
        rst = 1'b1;
        #1 check("single_ready", 32'(bus.req_ready), 1);
        step();
        bus.req_valid[0] = 1'b0;
        check("single_cnt", 32'(bus.issue_cnt), 1);
        check("single_alu_a", 32'(bus.alu_data1), 'h1234);
        check("single_early", 32'(bus.resp_valid), 0);
        step();
        check("single_early2", 32'(bus.resp_valid), 0);
        step();
        check("single_valid", 32'(bus.resp_valid), 1);
        check("single_id", 32'(bus.resp_id), 0);
        check("single_result", 32'(bus.resp_result), 'h1245);
        check("single_err", 32'(bus.resp_err), 0);
        step();
        check("single_pulse", 32'(bus.resp_valid), 0);

        // Unsupported opcode from requester 1: zero result, error flagged.
        drive(1, 1'b1, 16'hFFFF, 16'h0001, 4'd7);
        #1 check("badop_ready", 32'(bus.req_ready), 2);
        step();
        bus.req_valid[1] = 1'b0;
        step();
        step();
        check("badop_valid", 32'(bus.resp_valid), 1);
        check("badop_id", 32'(bus.resp_id), 1);
        check("badop_result", 32'(bus.resp_result), 0);
        check("badop_err", 32'(bus.resp_err), 1);
        drain();

        // Two contending requesters alternate, responses in grant order.
        do_reset();
        resp_log.delete();
        for (int c = 0; c < 4; c++) begin
            drive_rand(0);
            drive_rand(1);
            #1 check("alt_ready", 32'(bus.req_ready), (c % 2 == 0) ? 1 : 2);
            step();
        end
        drain();
        check("alt_count", 32'(resp_log.size()), 4);
        for (int k = 0; k < 4; k++)
            check("alt_order", (k < resp_log.size()) ? 32'(resp_log[k]) : 32'hFFFF_FFFF, 32'(k % 2));

        // Stall for three cycles with everyone requesting.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) drive_rand(i);
            step();
        end
        bus.stall = 1'b1;
        #1 check("stall_ready0", 32'(bus.req_ready), 0);
        step();
        resp_log.delete();
        check("stall_ready1", 32'(bus.req_ready), 0);
        step();
        check("stall_ready2", 32'(bus.req_ready), 0);
        step();
        bus.stall = 1'b0;
        check("stall_inflight", 32'(resp_log.size()), 2);
        check("stall_first", (resp_log.size() > 0) ? 32'(resp_log[0]) : 32'hFFFF_FFFF, 2);
        check("stall_second", (resp_log.size() > 1) ? 32'(resp_log[1]) : 32'hFFFF_FFFF, 0);
        #1 check("stall_resume", 32'(bus.req_ready), 2);
        step();
        drain();

        // Reset one cycle after an accept discards the in-flight operation.
        do_reset();
        drive(0, 1'b1, 16'hBEEF, 16'h0101, 4'd1);
        drive(1, 1'b1, 16'h0F0F, 16'h00FF, 4'd2);
        step();
        rst = 1'b0;
        #1 check("midrst_cnt", 32'(bus.issue_cnt), 0);
        check("midrst_alu_a", 32'(bus.alu_data1), 0);
        check("midrst_ready", 32'(bus.req_ready), 0);
        resp_log.delete();
        step();
        step();
        step();
        check("midrst_no_resp", 32'(resp_log.size()), 0);
        rst = 1'b1;
        #1 check("midrst_first", 32'(bus.req_ready), 1);
        step();
        drain();

        // Counter wrap with a single requester granted every cycle.
        do_reset();
        for (int k = 0; k < 65536; k++) begin
            drive_rand(2);
            step();
            if (k == 65534) check("wrap_max", 32'(bus.issue_cnt), 'hFFFF);
        end
        bus.req_valid = '0;
        check("wrap_zero", 32'(bus.issue_cnt), 0);
        drain();

        // Random traffic, stalls and occasional resets against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                drive_rand(i);
                bus.req_valid[i] = ($urandom_range(0, 9) < 6);
            end
            bus.stall = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1;
        drain();
        check("drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
